mcycle_seq: RTL and testbench
=============================

MCYCLE_SEQ -- requirements
Module: mcycle_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 Port clk SHALL be an input, 1 bit: the 12 MHz core clock.
REQ-003 Port reset SHALL be an input, 1 bit: asynchronous, active-high reset.
REQ-004 Port EA SHALL be an input, 1 bit: high selects internal ROM, low selects external ROM.
REQ-005 Port hold SHALL be an input, 1 bit: stall request, sampled only at a machine-cycle boundary.
REQ-006 Port ins_bytes SHALL be an input, 2 bits: instruction length in bytes from the decoder (0 means 1; valid range 1..3).
REQ-007 Port ins_cycles SHALL be an input, 2 bits: machine-cycle count from the decoder (00=1, 01=2, 10=4, 11=4).
REQ-008 Port ALE SHALL be an output, 1 bit: address latch enable.
REQ-009 Port PSEN SHALL be an output, 1 bit: program store enable, active low.
REQ-010 Ports IR_en and PC_en SHALL be outputs, 1 bit each: one-clock load strobes for the instruction register and the program counter.
REQ-011 Port opnd_en SHALL be an output, 2 bits: one-hot load strobe for operand byte 1 ([0]) or operand byte 2 ([1]).
REQ-012 Port exec_en SHALL be an output, 1 bit: one-clock strobe marking instruction completion.
REQ-013 Ports state (3 bits, values S1..S6 coded 1..6), phase (1 bit, 0=P1, 1=P2) and mc_idx (2 bits, current machine cycle) SHALL be outputs.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and HOLD.
REQ-015 IDLE SHALL go to RUN on the first clock after reset deasserts.
REQ-016 In RUN, the phase counter cnt SHALL count 0..11 and wrap to 0; one wrap is one machine cycle.
REQ-017 state SHALL equal cnt/2+1 and phase SHALL equal cnt[0]; in IDLE and HOLD, state=1 and phase=0.
REQ-018 ALE SHALL be 1 only in RUN at cnt 1, 2, 7 and 8 (two pulses per machine cycle).
REQ-019 PSEN SHALL be 0 only in RUN with EA=0 at cnt 3-5 and 9-11; with EA=1, PSEN SHALL stay 1.
REQ-020 Fetch slots SHALL occur at cnt 4 and cnt 10; the fetch index SHALL be f = 2*mc_idx + slot.
REQ-021 At f=0, IR_en and PC_en SHALL both pulse.
REQ-022 At f=1 with eff_bytes>=2, opnd_en[0] and PC_en SHALL pulse.
REQ-023 At f=2 with eff_bytes=3, opnd_en[1] and PC_en SHALL pulse.
REQ-024 All other fetch slots SHALL be dummy fetches: PSEN still toggles, but no strobe pulses.
REQ-025 ins_bytes and ins_cycles SHALL be registered at cnt 5 of mc_idx 0.
REQ-026 eff_bytes SHALL equal max(1, ins_bytes).
REQ-027 eff_cycles SHALL equal max(decoded ins_cycles, ceil(eff_bytes/2)), so a 3-byte, 1-cycle request SHALL run as 2 cycles.
REQ-028 At cnt 11 of mc_idx = eff_cycles-1, exec_en SHALL pulse and mc_idx SHALL return to 0; otherwise mc_idx SHALL increment at cnt 11.
REQ-029 hold SHALL be sampled only on the exec_en clock; if hold=1, the next state SHALL be HOLD with cnt=0.
REQ-030 While in HOLD, ALE=0, PSEN=1 and all strobes SHALL be 0.
REQ-031 HOLD SHALL go to RUN on the clock where hold=0; cnt=0 on the first RUN clock.
REQ-032 hold changes outside the exec_en clock SHALL be ignored.
REQ-033 At most one of IR_en, opnd_en[0] and opnd_en[1] SHALL be high in any clock.
REQ-034 Output latency SHALL be 0 clocks: all outputs are combinational decodes of registered cnt, mc_idx and FSM state.

Reset
REQ-035 While reset=1, outputs SHALL be: ALE=0, PSEN=1, IR_en=0, PC_en=0, opnd_en=0, exec_en=0, state=1, phase=0, mc_idx=0, with the FSM in IDLE and cnt=0.
REQ-036 A reset asserted mid-instruction SHALL abort it immediately with no exec_en; the next fetch after release SHALL be a new opcode (f=0).

Configuration
REQ-037 With MCYCLE_SEQ_INSTR_CNT_EN defined, the block SHALL add output instr_cnt (16 bits, reset 0) that increments on each exec_en and wraps 0xFFFF->0x0000.
REQ-038 Without MCYCLE_SEQ_INSTR_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-039 Shared package mcycle_pkg SHALL hold: CLK_PER_MC=12, SLOT0_CNT=4, SLOT1_CNT=10, ALE and PSEN cnt windows, the FSM state encoding, and the S1..S6 codes.
REQ-040 The block SHALL contain one sub-module, mcycle_phase_cnt: a mod-12 counter with enable and clear that outputs cnt and a wrap flag.

Verification
REQ-041 Reset, then release with EA=0, ins_bytes=1, ins_cycles=00 -> IR_en and PC_en at clock 5 after RUN entry (cnt 4); exec_en at cnt 11; one PC_en per 12 clocks; opnd_en never set.
REQ-042 ins_bytes=2, ins_cycles=01 -> IR_en at M0 cnt 4; opnd_en[0] and PC_en at M0 cnt 10; M1 slots are dummies; exec_en at M1 cnt 11, i.e. 24 clocks per instruction.
REQ-043 ins_bytes=3, ins_cycles=00 -> promoted to 2 cycles; opnd_en[1] and PC_en at M1 cnt 4; exec_en after 24 clocks.
REQ-044 EA=1 with any instruction -> PSEN constant 1; ALE high at cnt 1, 2, 7, 8 in every machine cycle.
REQ-045 hold=1 on an exec_en clock, held 5 clocks -> no ALE or strobes for 5 clocks; cnt=0 restarts on the first clock with hold=0; hold pulsed mid-cycle -> no effect.
REQ-046 reset pulsed at M1 cnt 6 of a 4-cycle instruction -> outputs at reset values, no exec_en, and after release IR_en at cnt 4 of the new M0.

Source files
------------

// File: rtl/mcycle_pkg.sv
// Shared constants for the machine-cycle sequencer: phase-count windows,
// fetch slot positions, FSM state encoding and S1..S6 state codes.
package mcycle_pkg;

  // Twelve oscillator clocks make one machine cycle (six states of two phases)
  localparam int         CLK_PER_MC = 12;
  localparam logic [3:0] CNT_LAST   = 4'(CLK_PER_MC - 1);

  // Opcode/operand fetch slots inside a machine cycle
  localparam logic [3:0] SLOT0_CNT  = 4'd4;
  localparam logic [3:0] SLOT1_CNT  = 4'd10;

  // Phase count at which the decoder's length/cycle fields are captured
  localparam logic [3:0] REG_CNT    = 4'd5;

  // Two ALE pulses per machine cycle
  localparam logic [3:0] ALE_A_LO   = 4'd1;
  localparam logic [3:0] ALE_A_HI   = 4'd2;
  localparam logic [3:0] ALE_B_LO   = 4'd7;
  localparam logic [3:0] ALE_B_HI   = 4'd8;

  // Two PSEN low windows per machine cycle (external program fetch only)
  localparam logic [3:0] PSEN_A_LO  = 4'd3;
  localparam logic [3:0] PSEN_A_HI  = 4'd5;
  localparam logic [3:0] PSEN_B_LO  = 4'd9;
  localparam logic [3:0] PSEN_B_HI  = 4'd11;

  // Sequencer control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } fsm_state_t;

  // Machine-cycle state codes presented on the state output
  localparam logic [2:0] S1 = 3'd1;
  localparam logic [2:0] S2 = 3'd2;
  localparam logic [2:0] S3 = 3'd3;
  localparam logic [2:0] S4 = 3'd4;
  localparam logic [2:0] S5 = 3'd5;
  localparam logic [2:0] S6 = 3'd6;

  // True when cnt lies in the inclusive window lo..hi
  function automatic logic in_window(input logic [3:0] cnt,
                                     input logic [3:0] lo,
                                     input logic [3:0] hi);
    return (cnt >= lo) && (cnt <= hi);
  endfunction

  // Maps the phase-pair index (cnt/2) onto S1..S6
  function automatic logic [2:0] state_code(input logic [2:0] pair);
    case (pair)
      3'd0:    return S1;
      3'd1:    return S2;
      3'd2:    return S3;
      3'd3:    return S4;
      3'd4:    return S5;
      3'd5:    return S6;
      default: return S1;
    endcase
  endfunction

endpackage

// File: rtl/mcycle_phase_cnt.sv
// Mod-12 phase counter with enable and synchronous clear; wrap flags the
// last phase of a machine cycle while counting.
module mcycle_phase_cnt
  import mcycle_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] cnt,
  output logic       wrap
);

  assign wrap = en && (cnt == CNT_LAST);

  // Advance the phase count, folding back to 0 after the last phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? 4'd0 : cnt + 4'd1;
    end
  end

endmodule

// File: rtl/mcycle_seq.sv
// Machine-cycle sequencer: generates ALE/PSEN timing and the instruction
// register, program counter, operand and execute strobes for 1..3 byte,
// 1/2/4 machine-cycle instructions, with a hold stall at instruction end.
// Optional feature: define MCYCLE_SEQ_INSTR_CNT_EN to add a 16-bit
// retired-instruction counter on output instr_cnt.
module mcycle_seq
  import mcycle_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        EA,
  input  logic        hold,
  input  logic [1:0]  ins_bytes,
  input  logic [1:0]  ins_cycles,
  output logic        ALE,
  output logic        PSEN,
  output logic        IR_en,
  output logic        PC_en,
  output logic [1:0]  opnd_en,
  output logic        exec_en,
  output logic [2:0]  state,
  output logic        phase,
  output logic [1:0]  mc_idx
`ifdef MCYCLE_SEQ_INSTR_CNT_EN
  ,
  output logic [15:0] instr_cnt
`endif
);

  fsm_state_t fsm_q;
  fsm_state_t fsm_d;

  logic       run;
  logic [3:0] cnt;
  logic       wrap;

  logic [1:0] bytes_q;
  logic [1:0] cycles_q;
  logic [1:0] eff_bytes;
  logic [1:0] dec_cycles_m1;
  logic [1:0] min_cycles_m1;
  logic [1:0] eff_cycles_m1;

  logic       fetch_slot;
  logic [2:0] fetch_idx;

  assign run = (fsm_q == ST_RUN);

  mcycle_phase_cnt u_phase_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (run),
    .clr   (!run),
    .cnt   (cnt),
    .wrap  (wrap)
  );

  // Effective length and cycle count; a 3-byte instruction needs two cycles
  always_comb begin
    eff_bytes     = (bytes_q == 2'd0) ? 2'd1 : bytes_q;
    dec_cycles_m1 = cycles_q[1] ? 2'd3 : {1'b0, cycles_q[0]};
    min_cycles_m1 = (eff_bytes == 2'd3) ? 2'd1 : 2'd0;
    eff_cycles_m1 = (dec_cycles_m1 > min_cycles_m1) ? dec_cycles_m1 : min_cycles_m1;
  end

  assign exec_en = wrap && (mc_idx == eff_cycles_m1);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q <= ST_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // Next state: start after reset, stall only at an instruction boundary
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE: fsm_d = ST_RUN;
      ST_RUN:  if (exec_en && hold) fsm_d = ST_HOLD;
      ST_HOLD: if (!hold) fsm_d = ST_RUN;
      default: fsm_d = ST_IDLE;
    endcase
  end

  // Machine-cycle index within the current instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mc_idx <= '0;
    end else if (!run) begin
      mc_idx <= '0;
    end else if (wrap) begin
      mc_idx <= exec_en ? 2'd0 : mc_idx + 2'd1;
    end
  end

  // Capture the decoder's length and cycle fields once the opcode has landed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bytes_q  <= '0;
      cycles_q <= '0;
    end else if (run && (cnt == REG_CNT) && (mc_idx == 2'd0)) begin
      bytes_q  <= ins_bytes;
      cycles_q <= ins_cycles;
    end
  end

  assign fetch_slot = run && ((cnt == SLOT0_CNT) || (cnt == SLOT1_CNT));
  assign fetch_idx  = {mc_idx, (cnt == SLOT1_CNT)};

  // Bus timing and load strobes decoded from the phase count and cycle index
  always_comb begin
    ALE     = 1'b0;
    PSEN    = 1'b1;
    IR_en   = 1'b0;
    PC_en   = 1'b0;
    opnd_en = 2'b00;
    state   = S1;
    phase   = 1'b0;
    if (run) begin
      state = state_code(cnt[3:1]);
      phase = cnt[0];
      ALE   = in_window(cnt, ALE_A_LO, ALE_A_HI) || in_window(cnt, ALE_B_LO, ALE_B_HI);
      PSEN  = !(!EA && (in_window(cnt, PSEN_A_LO, PSEN_A_HI) ||
                        in_window(cnt, PSEN_B_LO, PSEN_B_HI)));
      if (fetch_slot) begin
        case (fetch_idx)
          3'd0: begin
            IR_en = 1'b1;
            PC_en = 1'b1;
          end
          3'd1: begin
            if (eff_bytes >= 2'd2) begin
              opnd_en = 2'b01;
              PC_en   = 1'b1;
            end
          end
          3'd2: begin
            if (eff_bytes == 2'd3) begin
              opnd_en = 2'b10;
              PC_en   = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef MCYCLE_SEQ_INSTR_CNT_EN
  // Retired-instruction count, wrapping naturally at 16 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_cnt <= '0;
    end else if (exec_en) begin
      instr_cnt <= instr_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mcycle_seq.sv
// Directed bench for mcycle_seq: reset values, 1/2/3-byte fetch timing,
// internal-ROM PSEN behaviour, hold stall and mid-instruction reset.
module tb_mcycle_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       EA = 1'b0;
  logic       hold = 1'b0;
  logic [1:0] ins_bytes = 2'd1;
  logic [1:0] ins_cycles = 2'd0;
  logic       ALE;
  logic       PSEN;
  logic       IR_en;
  logic       PC_en;
  logic [1:0] opnd_en;
  logic       exec_en;
  logic [2:0] state;
  logic       phase;
  logic [1:0] mc_idx;
`ifdef MCYCLE_SEQ_INSTR_CNT_EN
  logic [15:0] instr_cnt;
`endif

  int checks = 0;
  int failures = 0;

  int n_ale, n_psen_lo, n_ir, n_pc, n_op0, n_op1, n_ex, n_multi;

  mcycle_seq dut (
    .clk        (clk),
    .reset      (reset),
    .EA         (EA),
    .hold       (hold),
    .ins_bytes  (ins_bytes),
    .ins_cycles (ins_cycles),
    .ALE        (ALE),
    .PSEN       (PSEN),
    .IR_en      (IR_en),
    .PC_en      (PC_en),
    .opnd_en    (opnd_en),
    .exec_en    (exec_en),
    .state      (state),
    .phase      (phase),
    .mc_idx     (mc_idx)
`ifdef MCYCLE_SEQ_INSTR_CNT_EN
    ,
    .instr_cnt  (instr_cnt)
`endif
  );

  // 12 MHz-style free-running clock
  always #5 clk = ~clk;

  task automatic stepClock(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic ea_v, input logic [1:0] bytes_v,
                               input logic [1:0] cycles_v, input logic hold_v);
    EA         = ea_v;
    ins_bytes  = bytes_v;
    ins_cycles = cycles_v;
    hold       = hold_v;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Samples n consecutive clocks (sample, then advance) and tallies activity
  task automatic countWindow(input int n);
    n_ale = 0; n_psen_lo = 0; n_ir = 0; n_pc = 0;
    n_op0 = 0; n_op1 = 0; n_ex = 0; n_multi = 0;
    for (int i = 0; i < n; i++) begin
      n_ale     += int'(ALE);
      n_psen_lo += int'(!PSEN);
      n_ir      += int'(IR_en);
      n_pc      += int'(PC_en);
      n_op0     += int'(opnd_en[0]);
      n_op1     += int'(opnd_en[1]);
      n_ex      += int'(exec_en);
      if ((int'(IR_en) + int'(opnd_en[0]) + int'(opnd_en[1])) > 1) n_multi++;
      stepClock(1);
    end
  endtask

  initial begin
    $display("[TB] start");
    // Reset values
    applyStimulus(1'b0, 2'd1, 2'b00, 1'b0);
    stepClock(2);
    checkOutput("rst_ale", ALE, 0);
    checkOutput("rst_psen", PSEN, 1);
    checkOutput("rst_ir", IR_en, 0);
    checkOutput("rst_pc", PC_en, 0);
    checkOutput("rst_opnd", opnd_en, 0);
    checkOutput("rst_exec", exec_en, 0);
    checkOutput("rst_state", state, 1);
    checkOutput("rst_phase", phase, 0);
    checkOutput("rst_mc", mc_idx, 0);
`ifdef MCYCLE_SEQ_INSTR_CNT_EN
    checkOutput("rst_icnt", instr_cnt, 0);
`endif

    // 1-byte, 1-cycle instruction, external ROM
    reset = 1'b0;
    stepClock(1);
    checkOutput("b1_c0_state", state, 1);
    checkOutput("b1_c0_ale", ALE, 0);
    stepClock(1);
    checkOutput("b1_c1_ale", ALE, 1);
    checkOutput("b1_c1_phase", phase, 1);
    stepClock(1);
    checkOutput("b1_c2_state", state, 2);
    checkOutput("b1_c2_ale", ALE, 1);
    stepClock(1);
    checkOutput("b1_c3_psen", PSEN, 0);
    checkOutput("b1_c3_ale", ALE, 0);
    stepClock(1);
    checkOutput("b1_c4_ir", IR_en, 1);
    checkOutput("b1_c4_pc", PC_en, 1);
    checkOutput("b1_c4_state", state, 3);
    stepClock(7);
    checkOutput("b1_c11_exec", exec_en, 1);
    checkOutput("b1_c11_state", state, 6);
    stepClock(1);
    checkOutput("b1_next_exec", exec_en, 0);
    checkOutput("b1_next_mc", mc_idx, 0);
    countWindow(24);
    checkOutput("b1_win_pc", n_pc, 2);
    checkOutput("b1_win_ir", n_ir, 2);
    checkOutput("b1_win_op", n_op0 + n_op1, 0);
    checkOutput("b1_win_exec", n_ex, 2);
    checkOutput("b1_win_ale", n_ale, 8);
    checkOutput("b1_win_psen", n_psen_lo, 12);
`ifdef MCYCLE_SEQ_INSTR_CNT_EN
    checkOutput("b1_icnt", instr_cnt, 3);
`endif

    // 2-byte, 2-cycle instruction
    applyStimulus(1'b0, 2'd2, 2'b01, 1'b0);
    stepClock(4);
    checkOutput("b2_m0c4_ir", IR_en, 1);
    checkOutput("b2_m0c4_pc", PC_en, 1);
    stepClock(6);
    checkOutput("b2_m0c10_op", opnd_en, 2'b01);
    checkOutput("b2_m0c10_pc", PC_en, 1);
    checkOutput("b2_m0c10_ir", IR_en, 0);
    stepClock(1);
    checkOutput("b2_m0c11_exec", exec_en, 0);
    stepClock(5);
    checkOutput("b2_m1c4_mc", mc_idx, 1);
    checkOutput("b2_m1c4_pc", PC_en, 0);
    checkOutput("b2_m1c4_ir", IR_en, 0);
    stepClock(6);
    checkOutput("b2_m1c10_pc", PC_en, 0);
    checkOutput("b2_m1c10_op", opnd_en, 0);
    stepClock(1);
    checkOutput("b2_m1c11_exec", exec_en, 1);
    stepClock(1);
    countWindow(48);
    checkOutput("b2_win_exec", n_ex, 2);
    checkOutput("b2_win_pc", n_pc, 4);
    checkOutput("b2_win_op0", n_op0, 2);
    checkOutput("b2_win_op1", n_op1, 0);
    checkOutput("b2_win_ir", n_ir, 2);

    // 3-byte instruction requesting 1 cycle, promoted to 2
    applyStimulus(1'b0, 2'd3, 2'b00, 1'b0);
    stepClock(10);
    checkOutput("b3_m0c10_op", opnd_en, 2'b01);
    stepClock(1);
    checkOutput("b3_m0c11_exec", exec_en, 0);
    stepClock(5);
    checkOutput("b3_m1c4_op", opnd_en, 2'b10);
    checkOutput("b3_m1c4_pc", PC_en, 1);
    checkOutput("b3_m1c4_mc", mc_idx, 1);
    stepClock(7);
    checkOutput("b3_m1c11_exec", exec_en, 1);
    stepClock(1);
    countWindow(24);
    checkOutput("b3_win_exec", n_ex, 1);
    checkOutput("b3_win_pc", n_pc, 3);
    checkOutput("b3_win_op1", n_op1, 1);
    checkOutput("b3_win_multi", n_multi, 0);

    // Internal ROM, 4-cycle instruction
    applyStimulus(1'b1, 2'd1, 2'b10, 1'b0);
    countWindow(48);
    checkOutput("ea_win_psen", n_psen_lo, 0);
    checkOutput("ea_win_ale", n_ale, 16);
    checkOutput("ea_win_exec", n_ex, 1);
    checkOutput("ea_win_pc", n_pc, 1);
    checkOutput("ea_win_ir", n_ir, 1);

    // Hold raised on the exec_en clock
    applyStimulus(1'b0, 2'd1, 2'b00, 1'b0);
    stepClock(11);
    checkOutput("hold_c11_exec", exec_en, 1);
    hold = 1'b1;
    stepClock(1);
    countWindow(5);
    checkOutput("hold_win_ale", n_ale, 0);
    checkOutput("hold_win_pc", n_pc, 0);
    checkOutput("hold_win_ir", n_ir, 0);
    checkOutput("hold_win_psen", n_psen_lo, 0);
    checkOutput("hold_win_exec", n_ex, 0);
    checkOutput("hold_state", state, 1);
    hold = 1'b0;
    stepClock(1);
    checkOutput("hold_rel_c0_ale", ALE, 0);
    stepClock(1);
    checkOutput("hold_rel_c1_ale", ALE, 1);
    checkOutput("hold_rel_c1_phase", phase, 1);
    stepClock(3);
    checkOutput("hold_rel_c4_ir", IR_en, 1);

    // Hold pulsed mid-cycle is ignored
    hold = 1'b1;
    stepClock(3);
    checkOutput("midhold_c7_ale", ALE, 1);
    hold = 1'b0;
    stepClock(4);
    checkOutput("midhold_c11_exec", exec_en, 1);
    stepClock(2);
    checkOutput("midhold_c1_ale", ALE, 1);

    // Reset in M1 of a 4-cycle instruction
    applyStimulus(1'b0, 2'd1, 2'b11, 1'b0);
    stepClock(17);
    checkOutput("rmid_m1c6_mc", mc_idx, 1);
    checkOutput("rmid_m1c6_state", state, 4);
    reset = 1'b1;
    #1;
    checkOutput("rmid_rst_mc", mc_idx, 0);
    checkOutput("rmid_rst_state", state, 1);
    checkOutput("rmid_rst_psen", PSEN, 1);
    countWindow(3);
    checkOutput("rmid_rst_exec", n_ex, 0);
    checkOutput("rmid_rst_ale", n_ale, 0);
    reset = 1'b0;
    stepClock(5);
    checkOutput("rmid_new_ir", IR_en, 1);
    checkOutput("rmid_new_mc", mc_idx, 0);
    stepClock(7);
    checkOutput("rmid_new_c11_exec", exec_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
